pearson_hash_check: RTL and testbench

PEARSON_HASH_CHECK -- requirements
Module: pearson_hash_check

---
 rtl/pearson_pkg.sv | 22 ++
 rtl/pearson_table.sv | 13 +
 rtl/pearson_hash_check.sv | 106 ++++++++++
 tb/tb_pearson_hash_check.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pearson_pkg.sv
// Shared types and constants for the 32-bit / 8-bit Pearson hash checker.
// The permutation T[i] = (i*167 + 13) mod 256 is defined once here.
package pearson_pkg;

  localparam int unsigned MSG_BYTES = 4;
  localparam int unsigned HASH_W    = 8;
  localparam int unsigned MSG_W     = MSG_BYTES * HASH_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HASH = 2'd1,
    DONE = 2'd2
  } state_t;

  // 167 is odd, so the affine map is a bijection on 0..255
  function automatic logic [HASH_W-1:0] t_perm(input logic [HASH_W-1:0] i);
    logic [15:0] p;
    p = 16'(i) * 16'd167 + 16'd13;
    return p[HASH_W-1:0];
  endfunction

endpackage

// File: rtl/pearson_table.sv
// Combinational Pearson permutation lookup: 8-bit index in, 8-bit value out.
module pearson_table
  import pearson_pkg::*;
(
  input  logic [HASH_W-1:0] idx,
  output logic [HASH_W-1:0] val
);

  always_comb begin
    val = t_perm(idx);
  end

endmodule

// File: rtl/pearson_hash_check.sv
// Sequential Pearson hash over a 4-byte message, one byte per cycle through a
// single shared table, compared against a captured reference hash.
module pearson_hash_check
  import pearson_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] msg,
  input  logic [7:0]  expected,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  hash_out,
  output logic        match,
  output logic [7:0]  mismatch_cnt
);

  state_t            state;
  logic [MSG_W-1:0]  msg_r;
  logic [HASH_W-1:0] exp_r;
  logic [HASH_W-1:0] h;
  logic [1:0]        idx;

  logic [HASH_W-1:0] cur_byte;
  logic [HASH_W-1:0] tbl_idx;
  logic [HASH_W-1:0] tbl_val;

  always_comb begin
    cur_byte = '0;
    for (int unsigned b = 0; b < MSG_BYTES; b++) begin
      if (idx == 2'(b)) cur_byte = msg_r[HASH_W*b +: HASH_W];
    end
    tbl_idx = h ^ cur_byte;
  end

  pearson_table u_table (
    .idx (tbl_idx),
    .val (tbl_val)
  );

  // in_ready is registered, so it stays low for the first cycle after reset
  // release and rises the cycle after the output handshake.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      msg_r        <= '0;
      exp_r        <= '0;
      h            <= '0;
      idx          <= '0;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      hash_out     <= '0;
      match        <= 1'b0;
      mismatch_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            msg_r    <= msg;
            exp_r    <= expected;
            h        <= '0;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= HASH;
          end else begin
            in_ready <= 1'b1;
          end
        end

        HASH: begin
          h   <= tbl_val;
          idx <= idx + 2'd1;
          if (idx == 2'(MSG_BYTES - 1)) begin
            out_valid <= 1'b1;
            hash_out  <= tbl_val;
            match     <= (tbl_val == exp_r);
            state     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            if (!match && (mismatch_cnt != '1)) begin
              mismatch_cnt <= mismatch_cnt + 8'd1;
            end
            out_valid <= 1'b0;
            hash_out  <= '0;
            match     <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          hash_out  <= '0;
          match     <= 1'b0;
          in_ready  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pearson_hash_check.sv
// Self-checking bench for pearson_hash_check: table vectors, hold/abort
// sequences and a long back-to-back run against a plain arithmetic model.
module tb_pearson_hash_check;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] msg;
  logic [7:0]  expected;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  hash_out;
  logic        match;
  logic [7:0]  mismatch_cnt;

  pearson_hash_check dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .msg          (msg),
    .expected     (expected),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .hash_out     (hash_out),
    .match        (match),
    .mismatch_cnt (mismatch_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int model_cnt = 0;
  int perm [256];

  typedef struct {
    logic [31:0] m;
    logic [7:0]  e;
    logic [7:0]  want_hash;
    logic        want_match;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [7:0] model_hash(input logic [31:0] m);
    int h;
    h = 0;
    for (int i = 0; i < 4; i++) begin
      h = perm[h ^ int'((m >> (8 * i)) & 32'hFF)];
    end
    return 8'(h);
  endfunction

  function automatic int sat_inc(input int c);
    return (c >= 255) ? 255 : c + 1;
  endfunction

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) timeout(name);
  endtask

  // Latency counts the accept cycle as cycle 1.
  task automatic wait_out(input string name, output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (!out_valid) timeout(name);
  endtask

  task automatic run_txn(input logic [31:0] m, input logic [7:0] e,
                         input logic [7:0] wh, input logic wm);
    int lat;
    in_valid = 1'b1;
    msg      = m;
    expected = e;
    wait_ready("txn_ready");
    tick();
    in_valid = 1'b0;
    msg      = $urandom;
    expected = $urandom;
    check("busy_in_ready", 32'(in_ready), 32'd0);
    wait_out("txn_out", lat);
    check("latency", 32'(lat), 32'd5);
    check("hash_out", 32'(hash_out), 32'(wh));
    check("match", 32'(match), 32'(wm));
    check("done_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if (!wm) model_cnt = sat_inc(model_cnt);
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_hash_zero", 32'(hash_out), 32'd0);
    check("post_match_zero", 32'(match), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("mismatch_cnt", 32'(mismatch_cnt), 32'(model_cnt));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [7:0]  held;
    int lat;
    int last_acc;

    for (int i = 0; i < 256; i++) perm[i] = (i * 167 + 13) % 256;

    vecs[0] = '{32'h0000_0000, 8'h90, 8'h90, 1'b1};
    vecs[1] = '{32'h0000_00FF, 8'h00, 8'hAF, 1'b0};
    vecs[2] = '{32'h0000_0000, 8'h91, 8'h90, 1'b0};
    vecs[3] = '{32'h0000_00FF, 8'hAF, 8'hAF, 1'b1};
    for (int i = 4; i < 8; i++) begin
      r = $urandom;
      vecs[i].m          = r;
      vecs[i].want_hash  = model_hash(r);
      vecs[i].want_match = i[0];
      vecs[i].e          = i[0] ? model_hash(r) : model_hash(r) ^ 8'(1 + $urandom_range(0, 254));
    end

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    msg       = '0;
    expected  = '0;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_hash", 32'(hash_out), 32'd0);
    check("rst_match", 32'(match), 32'd0);
    check("rst_cnt", 32'(mismatch_cnt), 32'd0);
    reset_n = 1'b1;
    tick();
    check("rel_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].m, vecs[i].e, vecs[i].want_hash, vecs[i].want_match);
    end

    // Stall in DONE while the input side keeps toggling.
    r = $urandom;
    in_valid = 1'b1;
    msg      = r;
    expected = model_hash(r) ^ 8'h5A;
    wait_ready("hold_ready");
    tick();
    wait_out("hold_out", lat);
    held = model_hash(r);
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      msg      = $urandom;
      expected = $urandom;
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_hash", 32'(hash_out), 32'(held));
      check("hold_match", 32'(match), 32'd0);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    model_cnt = sat_inc(model_cnt);
    check("hold_cnt", 32'(mismatch_cnt), 32'(model_cnt));

    // Reset during the second HASH cycle aborts the operation.
    in_valid = 1'b1;
    msg      = $urandom;
    expected = 8'h00;
    wait_ready("abort_ready");
    tick();
    in_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    model_cnt = 0;
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_hash", 32'(hash_out), 32'd0);
    check("abort_match", 32'(match), 32'd0);
    check("abort_cnt", 32'(mismatch_cnt), 32'd0);
    reset_n = 1'b1;
    tick();
    check("abort_rel_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end

    // Back-to-back mismatches drive the counter into saturation.
    out_ready = 1'b1;
    last_acc  = 0;
    for (int k = 0; k < 260; k++) begin
      r        = $urandom;
      in_valid = 1'b1;
      msg      = r;
      expected = model_hash(r) ^ 8'h01;
      wait_ready("b2b_ready");
      check("b2b_cnt", 32'(mismatch_cnt), 32'(model_cnt));
      tick();
      if (k > 0) check("b2b_spacing", 32'(cyc - last_acc), 32'd6);
      last_acc = cyc;
      wait_out("b2b_out", lat);
      check("b2b_hash", 32'(hash_out), 32'(model_hash(r)));
      model_cnt = sat_inc(model_cnt);
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check("sat_cnt", 32'(mismatch_cnt), 32'hFF);
    check("sat_model", 32'(model_cnt), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
